bin_frame_sched: RTL and testbench
==================================

// Module: bin_frame_sched
// PURPOSE
//  Frame scheduler for the 28x28 binarization engine. Arbitrates two frame sources
//  (0 = camera capture buffer, 1 = host/UART image loader) round-robin. Streams the
//  granted source's frame from its buffer into the engine and forwards the binary result
//  downstream, tagged with its source. Reports completion or timeout per frame.
// PARAMETERS
//  IMG_SIZE  784   pixels per frame
//  ADDR_W    10    source buffer address width, >= clog2(IMG_SIZE)
//  TIMEOUT   2048  max cycles in WAIT before abort (> IMG_SIZE+2)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  req            in   2       level frame-ready request per source; held until its ack
//  gnt            out  2       one-hot grant; held for the whole frame
//  ack            out  2       1-cycle pulse to the served source at frame end (ok or err)
//  src_rd_en      out  1       buffer read strobe, shared by both sources
//  src_rd_addr    out  ADDR_W  buffer read address
//  src_rd_data0   in   8       source 0 read data, 1-cycle read latency
//  src_rd_data1   in   8       source 1 read data, 1-cycle read latency
//  bin_frame_start out 1       frame-start pulse to the engine
//  bin_pixel      out  8       grey pixel to the engine
//  bin_valid      out  1       bin_pixel valid
//  bin_pix_in     in   1       engine binary output
//  bin_valid_in   in   1       engine output valid
//  bin_done_in    in   1       engine frame_done; coincides with the last output beat
//  out_pixel      out  1       forwarded binary pixel
//  out_valid      out  1       out_pixel valid; out_pixel/out_valid are a 1-cycle registered copy
//  out_src        out  1       source index of the frame being forwarded
//  frame_ok       out  1       pulse: IMG_SIZE outputs received and engine done
//  frame_err      out  1       pulse: timeout or output-count mismatch
//  busy           out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: every output is 0, FSM = IDLE, RR pointer = source 0, all counters 0.
//  FSM states: IDLE -> START -> FEED -> WAIT -> DONE -> IDLE.
//  - IDLE: if req != 0, grant by RR. Prefer the source opposite to last served; after reset
//    prefer source 0. Both requesting -> non-preferred waits. gnt is registered.
//  - START (1 cycle): gnt valid, bin_frame_start = 1, no pixel valid this cycle.
//  - FEED (IMG_SIZE cycles): src_rd_en = 1, addr 0..IMG_SIZE-1.
//    bin_valid = src_rd_en delayed 1 cycle; bin_pixel = granted data mux.
//    Exit after the addr IMG_SIZE-1 read is issued; the final bin_valid occurs in the
//    first WAIT cycle.
//  - WAIT: the timeout counter runs from WAIT entry and saturates. Output count is 11 bits
//    and counts bin_valid_in in FEED and WAIT. On bin_done_in, compare count (including the
//    current beat) to IMG_SIZE: equal -> frame_ok, else frame_err. If the counter reaches
//    TIMEOUT with no bin_done_in -> frame_err.
//  - DONE (1 cycle): ack[g] = 1; frame_ok/frame_err pulse here, mutually exclusive. The RR
//    pointer updates, gnt clears next cycle, FSM returns to IDLE.
//  Latency: req seen in IDLE -> bin_frame_start next cycle. Nominal frame is
//  1 + IMG_SIZE + 1 + 1 (engine calc) + IMG_SIZE + 1 cycles from grant.
//  Boundaries:
//  - req deasserted mid-frame is ignored and the frame completes.
//  - req held after ack is served again only once the other source is idle (RR fairness).
//  - bin_valid_in/bin_done_in outside FEED/WAIT are dropped, never forwarded.
//  - bin_done_in and the timeout in the same cycle: done wins.
//  - Async reset mid-frame aborts immediately with no ack. The next START re-syncs the
//    engine via frame_start.
// STRUCTURE
//  Shared package bin_pkg: IMG_SIZE, ADDR_W, FSM state localparams, source index constants.
//  One sub-module: rr_arb2 (2-way round-robin arbiter, registered one-hot grant, update on ack).
// TESTING
//  1. Only req=2'b01, engine model ok -> gnt=01 for the frame, 784 bin_valid, addr 0..783,
//     784 out_valid with out_src=0, one frame_ok, ack=01.
//  2. req=2'b11 from reset -> served source0, then source1; ack order 01,10. Three more
//     frames with both held -> alternation 0,1,0.
//  3. Engine model never asserts done -> frame_err exactly TIMEOUT cycles after WAIT entry,
//     ack pulses, busy drops.
//  4. Engine emits 783 outputs then done -> frame_err, not frame_ok.
//  5. Reset asserted at addr 400 of FEED -> all outputs 0 next edge. After release,
//     req=01 -> clean frame_ok.
//  6. Known image (max 200, threshold 62): out_pixel equals (pix>62) for all 784 pixels,
//     in address order.

Source files
------------

// File: rtl/bin_pkg.sv
// Shared constants for the binarization frame scheduler: frame geometry,
// FSM state encodings and frame-source indices.
package bin_pkg;
    localparam int BIN_IMG_SIZE = 784;
    localparam int BIN_ADDR_W   = 10;
    localparam int BIN_TIMEOUT  = 2048;
    localparam int BIN_CNT_W    = 11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic SRC_CAM  = 1'b0;
    localparam logic SRC_HOST = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered one-hot grant. The grant is held
// until the frame is acknowledged, and the pointer then moves to the other source.
module rr_arb2
    import bin_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    input  logic       ack_en,
    output logic [1:0] gnt
);
    logic [1:0] gnt_q, gnt_d;
    logic       pref_q, pref_d;

    always_comb begin
        gnt_d  = gnt_q;
        pref_d = pref_q;
        if (ack_en) begin
            gnt_d  = 2'b00;
            pref_d = gnt_q[SRC_HOST] ? SRC_CAM : SRC_HOST;
        end else if (grant_en && gnt_q == 2'b00 && req != 2'b00) begin
            if (req[pref_q])
                gnt_d = (pref_q == SRC_HOST) ? 2'b10 : 2'b01;
            else
                gnt_d = (pref_q == SRC_HOST) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= 2'b00;
            pref_q <= SRC_CAM;
        end else begin
            gnt_q  <= gnt_d;
            pref_q <= pref_d;
        end
    end

    assign gnt = gnt_q;
endmodule

// File: rtl/bin_frame_sched.sv
// Frame scheduler: grants one of two frame sources, streams its buffer into the
// binarization engine and forwards the tagged binary result with ok/err status.
//   state | meaning
//   IDLE  | waiting for a request; arbiter may grant
//   START | frame_start pulse to the engine
//   FEED  | one buffer read per cycle, addresses 0..IMG_SIZE-1
//   WAIT  | collecting engine output until done or timeout
//   DONE  | ack, frame_ok/frame_err pulse, arbiter pointer update
module bin_frame_sched
    import bin_pkg::*;
#(
    parameter int IMG_SIZE = BIN_IMG_SIZE,
    parameter int ADDR_W   = BIN_ADDR_W,
    parameter int TIMEOUT  = BIN_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [7:0]        src_rd_data0,
    input  logic [7:0]        src_rd_data1,
    output logic              bin_frame_start,
    output logic [7:0]        bin_pixel,
    output logic              bin_valid,
    input  logic              bin_pix_in,
    input  logic              bin_valid_in,
    input  logic              bin_done_in,
    output logic              out_pixel,
    output logic              out_valid,
    output logic              out_src,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              busy
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(IMG_SIZE - 1);
    localparam logic [BIN_CNT_W-1:0] CNT_FULL  = BIN_CNT_W'(IMG_SIZE);
    localparam logic [TMO_W-1:0]     TMO_LOAD  = TMO_W'(TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BIN_CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 ok_q, ok_d, err_q, err_d;
    logic                 bin_valid_q;
    logic                 out_valid_q, out_pixel_q, out_src_q;
    logic                 in_frame, fwd, cnt_match;

    assign in_frame  = (state_q == S_FEED) || (state_q == S_WAIT);
    assign fwd       = in_frame && bin_valid_in;
    assign cnt_match = (cnt_q + BIN_CNT_W'(bin_valid_in)) == CNT_FULL;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant_en (state_q == S_IDLE),
        .ack_en   (state_q == S_DONE),
        .gnt      (gnt)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (req != 2'b00) state_d = S_START;
            S_START: begin
                addr_d  = '0;
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                cnt_d = cnt_q + BIN_CNT_W'(fwd);
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    tmo_d   = TMO_LOAD;
                    state_d = S_WAIT;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + BIN_CNT_W'(fwd);
                if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
                // engine done takes priority over a coincident timeout
                if (bin_done_in) begin
                    ok_d    = cnt_match;
                    err_d   = !cnt_match;
                    state_d = S_DONE;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            bin_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            bin_valid_q <= (state_q == S_FEED);
            out_valid_q <= fwd;
            out_pixel_q <= fwd && bin_pix_in;
            if (fwd) out_src_q <= gnt[SRC_HOST];
        end
    end

    // read data arrives one cycle after the strobe, aligned with bin_valid
    assign bin_pixel       = bin_valid_q ? (gnt[SRC_HOST] ? src_rd_data1 : src_rd_data0) : 8'd0;
    assign bin_valid       = bin_valid_q;
    assign src_rd_en       = (state_q == S_FEED);
    assign src_rd_addr     = addr_q;
    assign bin_frame_start = (state_q == S_START);
    assign ack             = (state_q == S_DONE) ? gnt : 2'b00;
    assign frame_ok        = ok_q;
    assign frame_err       = err_q;
    assign busy            = (state_q != S_IDLE);
    assign out_valid       = out_valid_q;
    assign out_pixel       = out_pixel_q;
    assign out_src         = out_src_q;
endmodule

// File: tb/tb_bin_frame_sched.sv
// Bench for bin_frame_sched: random source images, a thresholding engine model and
// a frame-level reference (round-robin order, expected pixel stream, ok/err result).
module tb_bin_frame_sched;
    localparam int IMG = 784;
    localparam int TMO = 2048;
    localparam int THR = 62;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt, ack;
    logic       src_rd_en;
    logic [9:0] src_rd_addr;
    logic [7:0] src_rd_data0 = 8'd0, src_rd_data1 = 8'd0;
    logic       bin_frame_start, bin_valid, out_pixel, out_valid, out_src;
    logic       frame_ok, frame_err, busy;
    logic [7:0] bin_pixel;
    logic       bin_pix_in, bin_valid_in, bin_done_in;
    logic       eng_v = 1'b0, eng_p = 1'b0, eng_d = 1'b0;
    logic       stray_v = 1'b0, stray_d = 1'b0;
    int         eng_mode = 0;   // 0 normal, 1 never done, 2 one output short
    int         eng_n = 0;

    always #5 clk = ~clk;

    assign bin_valid_in = eng_v | stray_v;
    assign bin_pix_in   = eng_p | stray_v;
    assign bin_done_in  = eng_d | stray_d;

    bin_frame_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .ack(ack),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
        .src_rd_data0(src_rd_data0), .src_rd_data1(src_rd_data1),
        .bin_frame_start(bin_frame_start), .bin_pixel(bin_pixel), .bin_valid(bin_valid),
        .bin_pix_in(bin_pix_in), .bin_valid_in(bin_valid_in), .bin_done_in(bin_done_in),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_src(out_src),
        .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
    );

    logic [30:0] outs_all;
    assign outs_all = {gnt, ack, src_rd_en, src_rd_addr, bin_frame_start, bin_pixel, bin_valid,
                       out_pixel, out_valid, out_src, frame_ok, frame_err, busy};

    logic [7:0] mem0 [IMG];
    logic [7:0] mem1 [IMG];

    always @(posedge clk)
        if (src_rd_en) begin
            src_rd_data0 <= mem0[src_rd_addr];
            src_rd_data1 <= mem1[src_rd_addr];
        end

    // engine: one-cycle threshold, done on the last output beat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_v <= 1'b0; eng_p <= 1'b0; eng_d <= 1'b0; eng_n <= 0;
        end else begin
            eng_v <= 1'b0; eng_p <= 1'b0; eng_d <= 1'b0;
            if (bin_frame_start) eng_n <= 0;
            else if (bin_valid && !(eng_mode == 2 && eng_n >= IMG - 1)) begin
                eng_v <= 1'b1;
                eng_p <= (bin_pixel > 8'(THR));
                eng_n <= eng_n + 1;
                if (eng_mode == 0 && eng_n == IMG - 1) eng_d <= 1'b1;
                if (eng_mode == 2 && eng_n == IMG - 2) eng_d <= 1'b1;
            end
        end
    end

    // per-frame monitor; frame-local tallies restart at each frame_start
    int   cyc = 0, n_rd = 0, addr_bad = 0, n_bv = 0, n_ok = 0, n_err = 0, n_ack = 0;
    int   gnt_chg = 0, wait_cyc = 0, err_cyc = 0, n_out_total = 0;
    logic [1:0] gnt_start = 2'b00;
    logic q_pix[$];
    logic q_src[$];

    always @(negedge clk) if (rst_n) begin
        cyc++;
        if (bin_frame_start) begin
            n_rd = 0; addr_bad = 0; n_bv = 0; n_ok = 0; n_err = 0; n_ack = 0; gnt_chg = 0;
            q_pix.delete(); q_src.delete();
            gnt_start = gnt;
        end
        if (src_rd_en) begin
            if (int'(src_rd_addr) != n_rd) addr_bad++;
            n_rd++;
        end
        if (bin_valid) n_bv++;
        if (bin_valid && !src_rd_en) wait_cyc = cyc;
        if (out_valid) begin
            q_pix.push_back(out_pixel); q_src.push_back(out_src); n_out_total++;
        end
        if (frame_ok) n_ok++;
        if (frame_err) begin n_err++; err_cyc = cyc; end
        if (ack != 2'b00) n_ack++;
        if (busy && gnt !== gnt_start) gnt_chg++;
    end

    int errors = 0;
    int checks = 0;
    int pref = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_mems();
        for (int i = 0; i < IMG; i++) begin
            mem0[i] = 8'($urandom_range(0, 200));
            mem1[i] = 8'($urandom_range(0, 200));
        end
        mem0[0] = 8'd62; mem0[1] = 8'd63; mem1[0] = 8'd200; mem1[1] = 8'd0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; pref = 0;
    endtask

    task automatic do_frame(input logic [1:0] r, input logic [1:0] r_after,
                            input int mode, input bit drop_mid);
        int s, n_exp, mism, lim;
        logic [1:0] a, s_oh;
        logic s_bit, e_bit;
        bit got;
        s     = r[pref] ? pref : 1 - pref;
        s_bit = s[0];
        s_oh  = s_bit ? 2'b10 : 2'b01;
        eng_mode = mode;
        fill_mems();
        req = r; got = 0; a = 2'b00;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (drop_mid && busy) req = 2'b00;
            if (ack !== 2'b00) begin a = ack; got = 1; break; end
        end
        req = r_after;
        @(negedge clk);
        pref = 1 - s;
        check("ack_seen", int'(got), 1);
        check("ack_value", int'(a), int'(s_oh));
        check("ack_pulses", n_ack, 1);
        check("gnt_at_start", int'(gnt_start), int'(s_oh));
        check("gnt_held", gnt_chg, 0);
        check("rd_count", n_rd, IMG);
        check("rd_addr_order", addr_bad, 0);
        check("bin_valid_count", n_bv, IMG);
        n_exp = (mode == 2) ? IMG - 1 : IMG;
        check("out_count", q_pix.size(), n_exp);
        lim = (q_pix.size() < n_exp) ? q_pix.size() : n_exp;
        mism = 0;
        for (int i = 0; i < lim; i++) begin
            e_bit = s_bit ? (mem1[i] > 8'(THR)) : (mem0[i] > 8'(THR));
            if (q_pix[i] !== e_bit || q_src[i] !== s_bit) mism++;
        end
        check("out_pixels", mism, 0);
        check("frame_ok", n_ok, (mode == 0) ? 1 : 0);
        check("frame_err", n_err, (mode != 0) ? 1 : 0);
        check("busy_after", int'(busy), 0);
        if (mode == 1) check("timeout_latency", err_cyc - wait_cyc, TMO);
    endtask

    initial begin
        int base;
        bit hit;
        fill_mems();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'(outs_all), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        base = n_out_total;
        stray_v = 1'b1; stray_d = 1'b1;
        repeat (3) @(negedge clk);
        stray_v = 1'b0; stray_d = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_dropped", n_out_total - base, 0);
        check("stray_no_result", n_ok + n_err, 0);
        check("stray_idle", int'(busy), 0);

        do_frame(2'b01, 2'b00, 0, 0);

        apply_reset();
        for (int k = 0; k < 5; k++) do_frame(2'b11, (k == 4) ? 2'b00 : 2'b11, 0, 0);

        for (int k = 0; k < 4; k++)
            do_frame(2'($urandom_range(1, 3)), 2'b00, 0, 1'($urandom_range(0, 1)));

        do_frame(2'b01, 2'b00, 1, 0);
        do_frame(2'b10, 2'b00, 2, 0);

        req = 2'b01; hit = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (src_rd_en && src_rd_addr == 10'd400) begin hit = 1; break; end
        end
        check("reached_addr400", int'(hit), 1);
        rst_n = 1'b0; req = 2'b00;
        @(posedge clk); #1;
        check("abort_outputs", int'(outs_all), 0);
        check("abort_no_ack", n_ack, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; pref = 0;
        do_frame(2'b01, 2'b00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
